divider_sweep_ctrl: RTL and testbench

- Sequencer that drives the Scale input of the clock Divider and steps it through a programmed range.
- Dwells a programmed number of Slow_clk rising edges at each value.
- Used to sweep a tone or blink rate without CPU or switch intervention; sits between the control inputs and Divider.Scale.
- Runs entirely in the sysclk domain; Slow_clk is fed back in and synchronised.

---
 rtl/divider_sweep_ctrl_if.sv | 28 ++
 rtl/divider_sweep_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_divider_sweep_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/divider_sweep_ctrl_if.sv
// Control/status bundle between the sweep sequencer and whatever drives it.
// master: the controller issuing start/stop and range configuration.
// slave : the divider_sweep_ctrl sequencer itself.
interface divider_sweep_ctrl_if #(
  parameter int unsigned SCALE_W = 6,
  parameter int unsigned DWELL_W = 8
) ();
  logic               start;
  logic               stop;
  logic               mode;
  logic [SCALE_W-1:0] scale_lo;
  logic [SCALE_W-1:0] scale_hi;
  logic [DWELL_W-1:0] dwell;
  logic [SCALE_W-1:0] scale_out;
  logic               busy;
  logic               step_pulse;
  logic               done;

  modport master (
    output start, stop, mode, scale_lo, scale_hi, dwell,
    input  scale_out, busy, step_pulse, done
  );

  modport slave (
    input  start, stop, mode, scale_lo, scale_hi, dwell,
    output scale_out, busy, step_pulse, done
  );
endinterface

// File: rtl/divider_sweep_ctrl.sv
// divider_sweep_ctrl: steps Divider.Scale through [scale_lo, scale_hi],
// dwelling a programmed number of Slow_clk rising edges per value.
// mode 0 = single up-sweep ending in a done pulse; mode 1 = endless triangle.
// Optional macro DIVSWEEP_SETTLE_EN: discard the first tick after every
// scale change so the Divider can settle on its new Scale.
module divider_sweep_ctrl #(
  parameter int unsigned SCALE_W     = 6,
  parameter int unsigned DWELL_W     = 8,
  parameter int unsigned RESET_SCALE = 1
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 slow_clk_in,
  divider_sweep_ctrl_if.slave  bus
);

`ifdef DIVSWEEP_SETTLE_EN
  localparam bit SETTLE_EN = 1'b1;
`else
  localparam bit SETTLE_EN = 1'b0;
`endif

  localparam logic [SCALE_W-1:0] RST_SCALE = SCALE_W'(RESET_SCALE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DWELL,
    S_STEP,
    S_DONE
  } state_t;

  state_t             state_q, state_n;
  logic               sync1_q, sync2_q, sync3_q, tick_q;
  logic [SCALE_W-1:0] scale_q, scale_n;
  logic [DWELL_W-1:0] cnt_q, cnt_n;
  logic               dir_up_q, dir_up_n;
  logic               settle_q, settle_n;
  logic               step_q, step_n;
  logic               load_cfg;
  logic [SCALE_W-1:0] lo_q, hi_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               mode_q;
  logic [DWELL_W-1:0] eff_dwell;
  logic               dwell_hit;
  logic               degenerate;

  assign eff_dwell  = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
  assign dwell_hit  = ({1'b0, cnt_q} + 1'b1) == {1'b0, eff_dwell};
  assign degenerate = (lo_q >= hi_q);

  // Synchronise Slow_clk and register a one-cycle tick on its rising edge
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= slow_clk_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      tick_q  <= sync2_q & ~sync3_q;
    end
  end

  // Sequencer state and datapath registers
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      scale_q  <= RST_SCALE;
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
      settle_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      scale_q  <= scale_n;
      cnt_q    <= cnt_n;
      dir_up_q <= dir_up_n;
      settle_q <= settle_n;
      step_q   <= step_n;
    end
  end

  // Configuration captured once on start; ignored until the next IDLE
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      lo_q    <= '0;
      hi_q    <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
    end else if (load_cfg) begin
      lo_q    <= bus.scale_lo;
      hi_q    <= bus.scale_hi;
      dwell_q <= bus.dwell;
      mode_q  <= bus.mode;
    end
  end

  // Next-state, datapath update and stop override
  always_comb begin
    state_n  = state_q;
    scale_n  = scale_q;
    cnt_n    = cnt_q;
    dir_up_n = dir_up_q;
    settle_n = settle_q;
    step_n   = 1'b0;
    load_cfg = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          load_cfg = 1'b1;
          state_n  = S_LOAD;
        end
      end
      S_LOAD: begin
        scale_n  = lo_q;
        cnt_n    = '0;
        dir_up_n = 1'b1;
        settle_n = SETTLE_EN && !degenerate;
        state_n  = S_DWELL;
      end
      S_DWELL: begin
        if (tick_q) begin
          if (settle_q) begin
            settle_n = 1'b0;
          end else if (dwell_hit) begin
            state_n = S_STEP;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
      end
      S_STEP: begin
        cnt_n   = '0;
        state_n = S_DWELL;
        if (degenerate) begin
          if (!mode_q) state_n = S_DONE;
        end else if (dir_up_q) begin
          if (scale_q < hi_q) begin
            scale_n  = scale_q + 1'b1;
            step_n   = 1'b1;
            settle_n = SETTLE_EN;
          end else if (!mode_q) begin
            state_n = S_DONE;
          end else begin
            dir_up_n = 1'b0;
            scale_n  = scale_q - 1'b1;
            step_n   = 1'b1;
            settle_n = SETTLE_EN;
          end
        end else begin
          if (scale_q > lo_q) begin
            scale_n = scale_q - 1'b1;
          end else begin
            dir_up_n = 1'b1;
            scale_n  = scale_q + 1'b1;
          end
          step_n   = 1'b1;
          settle_n = SETTLE_EN;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // stop overrides everything decided above, including a pending step
    if (bus.stop && state_q != S_IDLE) begin
      state_n  = S_IDLE;
      scale_n  = scale_q;
      step_n   = 1'b0;
      settle_n = 1'b0;
    end
  end

  assign bus.scale_out  = scale_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.step_pulse = step_q;
  assign bus.done       = (state_q == S_DONE) && !bus.stop;

endmodule

// File: tb/tb_divider_sweep_ctrl.sv
// Self-checking bench for divider_sweep_ctrl. Expected values come from a
// closed-form sweep model indexed by the number of Slow_clk ticks delivered.
module tb_divider_sweep_ctrl;

`ifdef DIVSWEEP_SETTLE_EN
  localparam int SETTLE = 1;
`else
  localparam int SETTLE = 0;
`endif

  logic sysclk = 1'b0;
  logic reset;
  logic slow_clk_in;
  int   total = 0;
  int   bad   = 0;
  int   sp_cnt = 0;
  int   dn_cnt = 0;

  divider_sweep_ctrl_if #(.SCALE_W(6), .DWELL_W(8)) bus ();

  divider_sweep_ctrl #(
    .SCALE_W(6),
    .DWELL_W(8),
    .RESET_SCALE(1)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .slow_clk_in (slow_clk_in),
    .bus         (bus)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (bus.step_pulse === 1'b1) sp_cnt++;
    if (bus.done === 1'b1) dn_cnt++;
  end

  // Expected state after k ticks since the sweep was loaded.
  function automatic void model(input int lo, input int hi, input int dw, input int md,
                                input int k, output int sc, output bit bz,
                                output int steps, output int dones);
    int eff, n, per, s, p;
    eff = (dw == 0) ? 1 : dw;
    n   = hi - lo;
    if (lo >= hi) begin
      per   = eff;
      s     = k / per;
      sc    = lo;
      steps = 0;
      if (md == 0 && s >= 1) begin bz = 1'b0; dones = 1; end
      else begin bz = 1'b1; dones = 0; end
    end else begin
      per = eff + SETTLE;
      s   = k / per;
      if (md == 0) begin
        if (s > n) begin sc = hi; bz = 1'b0; dones = 1; steps = n; end
        else begin sc = lo + s; bz = 1'b1; dones = 0; steps = s; end
      end else begin
        p     = s % (2 * n);
        sc    = (p <= n) ? lo + p : lo + 2 * n - p;
        bz    = 1'b1;
        dones = 0;
        steps = s;
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge sysclk); #1 slow_clk_in = ~slow_clk_in;
    end
    slow_clk_in = 1'b0;
    @(posedge sysclk); #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sysclk);
      total++;
      if (bus.scale_out !== 6'd1 || bus.busy !== 1'b0 ||
          bus.step_pulse !== 1'b0 || bus.done !== 1'b0) begin
        bad++;
        $display("FAIL reset cycle %0d: scale_out=%0d busy=%b step=%b done=%b, need 1/0/0/0",
                 i, bus.scale_out, bus.busy, bus.step_pulse, bus.done);
      end
    end
  endtask

  task automatic test_start_with_stop();
    @(posedge sysclk); #1 bus.start = 1'b1; bus.stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      total++;
      if (bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL start_with_stop: busy=%b need 0", bus.busy);
      end
    end
    @(posedge sysclk); #1 bus.start = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic pulse_slow();
    @(posedge sysclk); #1 slow_clk_in = 1'b1;
    repeat (8) @(posedge sysclk);
  endtask

  task automatic finish_slow();
    repeat (2) @(posedge sysclk);
    #1 slow_clk_in = 1'b0;
    repeat (10) @(posedge sysclk);
  endtask

  task automatic run_sweep(input string name, input int lo, input int hi, input int dw,
                           input int md, input int nt);
    int sp0, dn0, sc, st, dn;
    bit bz;
    @(posedge sysclk); #1;
    bus.scale_lo = 6'(lo); bus.scale_hi = 6'(hi); bus.dwell = 8'(dw); bus.mode = md[0];
    bus.start = 1'b1;
    @(posedge sysclk); #1;
    bus.start = 1'b0;
    bus.scale_lo = 6'($urandom); bus.scale_hi = 6'($urandom);
    bus.dwell = 8'($urandom); bus.mode = 1'($urandom);
    sp0 = sp_cnt; dn0 = dn_cnt;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    total++;
    if (bus.scale_out !== 6'(lo) || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL %s load: scale_out=%0d busy=%b, need %0d/1", name, bus.scale_out, bus.busy, lo);
    end
    sc = lo; bz = 1'b1;
    for (int k = 1; k <= nt; k++) begin
      pulse_slow();
      @(negedge sysclk);
      model(lo, hi, dw, md, k, sc, bz, st, dn);
      total++;
      if (bus.scale_out !== 6'(sc)) begin
        bad++;
        $display("FAIL %s tick %0d scale_out: got %0d need %0d", name, k, bus.scale_out, sc);
      end
      total++;
      if (bus.busy !== bz) begin
        bad++;
        $display("FAIL %s tick %0d busy: got %b need %b", name, k, bus.busy, bz);
      end
      total++;
      if (sp_cnt - sp0 != st) begin
        bad++;
        $display("FAIL %s tick %0d step_pulse count: got %0d need %0d", name, k, sp_cnt - sp0, st);
      end
      total++;
      if (dn_cnt - dn0 != dn) begin
        bad++;
        $display("FAIL %s tick %0d done count: got %0d need %0d", name, k, dn_cnt - dn0, dn);
      end
      finish_slow();
    end
    if (bz) begin
      dn0 = dn_cnt; sp0 = sp_cnt;
      @(posedge sysclk); #1 bus.stop = 1'b1;
      @(posedge sysclk); #1 bus.stop = 1'b0;
      @(negedge sysclk);
      total++;
      if (bus.busy !== 1'b0 || bus.scale_out !== 6'(sc) || dn_cnt != dn0 || sp_cnt != sp0) begin
        bad++;
        $display("FAIL %s stop: busy=%b scale_out=%0d done+%0d step+%0d, need 0/%0d/0/0",
                 name, bus.busy, bus.scale_out, dn_cnt - dn0, sp_cnt - sp0, sc);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(posedge sysclk); #1;
    bus.scale_lo = 6'd10; bus.scale_hi = 6'd20; bus.dwell = 8'd1; bus.mode = 1'b1;
    bus.start = 1'b1;
    @(posedge sysclk); #1 bus.start = 1'b0;
    repeat (3) @(posedge sysclk);
    pulse_slow();
    finish_slow();
    #3 reset = 1'b1;
    #1;
    total++;
    if (bus.scale_out !== 6'd1 || bus.busy !== 1'b0 || bus.step_pulse !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_sweep: scale_out=%0d busy=%b step=%b done=%b, need 1/0/0/0",
               bus.scale_out, bus.busy, bus.step_pulse, bus.done);
    end
    @(posedge sysclk); #1 reset = 1'b0;
    repeat (2) @(posedge sysclk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_sweep("random", int'($urandom_range(0, 10)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                int'($urandom_range(1, 12)));
    end
  endtask

  initial begin
    reset = 1'b1; slow_clk_in = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
    bus.scale_lo = '0; bus.scale_hi = '0; bus.dwell = '0;
    test_reset();
    test_start_with_stop();
    run_sweep("mode0_3_5", 3, 5, 2, 0, 7);
    run_sweep("triangle_2_4", 2, 4, 1, 1, 9);
    run_sweep("degenerate_7", 7, 7, 0, 0, 3);
    run_sweep("stop_after_2", 1, 9, 1, 0, 2);
    run_sweep("reload_6", 6, 9, 1, 0, 1);
    run_sweep("settle_3_4", 3, 4, 2, 0, 7);
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
